rv32i_mem_arbiter: RTL and testbench

RV32I_MEM_ARBITER -- requirements
Module: rv32i_mem_arbiter

---
 rtl/fe_pkg.sv | 17 +
 rtl/rv32i_mem_arbiter_if.sv | 40 ++++
 rtl/rv32i_mem_arbiter.sv | 100 ++++++++++
 tb/tb_rv32i_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fe_pkg.sv
// Shared types and constants for the RV32I fetch/data memory arbiter.
package fe_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned BE_W             = 4;
  localparam int unsigned CNT_W            = 4;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  typedef logic [XLEN-1:0] RV32I_OPERAND_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_MEM  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rv32i_mem_arbiter_if.sv
// Fetch port, data port and unified memory port of the arbiter, bundled as one interface.
interface rv32i_mem_arbiter_if;
  import fe_pkg::*;

  logic            if_req;
  RV32I_OPERAND_t  if_addr;
  logic            if_done;
  RV32I_OPERAND_t  if_rdata;

  logic            d_req;
  logic            d_we;
  RV32I_OPERAND_t  d_addr;
  RV32I_OPERAND_t  d_wdata;
  logic [BE_W-1:0] d_be;
  logic            d_done;
  RV32I_OPERAND_t  d_rdata;

  logic            mem_req;
  logic            mem_we;
  RV32I_OPERAND_t  mem_addr;
  RV32I_OPERAND_t  mem_wdata;
  logic [BE_W-1:0] mem_be;
  logic            mem_ack;
  RV32I_OPERAND_t  mem_rdata;

  // Arbiter side: serves the two requesters and drives the memory.
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
    output if_done, if_rdata, d_done, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  // Environment side: core requesters plus the memory responder.
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
    input  if_done, if_rdata, d_done, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

endinterface

// File: rtl/rv32i_mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single unified memory, one transaction in flight.
// Optional fetch anti-starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module rv32i_mem_arbiter
  import fe_pkg::*;
`ifdef MEM_ARB_STARVE_GUARD_EN
  #(parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF)
`endif
(
  input logic                clk,
  input logic                rst,
  rv32i_mem_arbiter_if.slave bus
);

  arb_state_t state;
  logic       win_fetch;
  logic       grant_fetch_c;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [CNT_W-1:0] starve_cnt;

  // Data normally wins; fetch is forced once data has won STARVE_LIMIT times in a row over it.
  always_comb begin
    grant_fetch_c = bus.if_req &&
                    (!bus.d_req || (starve_cnt == CNT_W'(STARVE_LIMIT)));
  end
`else
  always_comb begin
    grant_fetch_c = bus.if_req && !bus.d_req;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ARB_IDLE;
      win_fetch     <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
      bus.if_done   <= 1'b0;
      bus.d_done    <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_rdata   <= '0;
`ifdef MEM_ARB_STARVE_GUARD_EN
      starve_cnt    <= '0;
`endif
    end else begin
      bus.if_done <= 1'b0;
      bus.d_done  <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (bus.if_req || bus.d_req) begin
            state       <= ARB_MEM;
            win_fetch   <= grant_fetch_c;
            bus.mem_req <= 1'b1;
            // Request fields are captured here so the memory side ignores later requester changes.
            if (grant_fetch_c) begin
              bus.mem_we    <= 1'b0;
              bus.mem_addr  <= bus.if_addr;
              bus.mem_wdata <= '0;
              bus.mem_be    <= {BE_W{1'b1}};
            end else begin
              bus.mem_we    <= bus.d_we;
              bus.mem_addr  <= bus.d_addr;
              bus.mem_wdata <= bus.d_wdata;
              bus.mem_be    <= bus.d_be;
            end
`ifdef MEM_ARB_STARVE_GUARD_EN
            if (grant_fetch_c) begin
              starve_cnt <= '0;
            end else if (bus.if_req) begin
              starve_cnt <= starve_cnt + CNT_W'(1);
            end
`endif
          end
        end
        ARB_MEM: begin
          if (bus.mem_ack) begin
            state       <= ARB_RESP;
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            if (win_fetch) begin
              bus.if_rdata <= bus.mem_rdata;
              bus.if_done  <= 1'b1;
            end else begin
              if (!bus.mem_we) begin
                bus.d_rdata <= bus.mem_rdata;
              end
              bus.d_done <= 1'b1;
            end
          end
        end
        ARB_RESP: state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Scoreboard bench for rv32i_mem_arbiter: directed scenarios plus randomized fetch/data traffic.
module tb_rv32i_mem_arbiter;
  import fe_pkg::*;

  localparam int unsigned LIMIT = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct {
    bit          fetch;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  rv32i_mem_arbiter_if bus ();
  rv32i_mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int   checks = 0;
  int   passes = 0;
  exp_t exp_q[$];
  bit   grant_log[$];
  int   ack_wait = 0;
  int   wait_cnt = 0;
  bit   rand_ack = 1'b0;
  int   done_count = 0;
  int   mreq_len = 0;
  int   last_mreq_len = 0;

  logic        p_mreq, p_ack, p_if, p_d, p_d_we;
  logic [31:0] p_if_addr, p_d_addr, p_d_wdata;
  logic [3:0]  p_d_be;
  logic [31:0] cap_addr, cap_wdata, cap_ctl;
  logic [31:0] last_load;
  int unsigned streak;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  // Memory contents as a pure function of the address; 0x10 holds an ADDI encoding.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h0000_0093;
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Memory responder: ack after ack_wait cycles of mem_req.
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ack = 1'b0;
      if (bus.mem_req && !rst) begin
        if (wait_cnt >= ack_wait) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem_word(bus.mem_addr);
          wait_cnt      = 0;
          if (rand_ack) ack_wait = int'($urandom_range(0, 3));
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: predicts winner and response at each grant, checks every done against the queue.
  initial begin
    bit   done_now, done_due, win_f;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        p_mreq = 0; p_ack = 0; p_if = 0; p_d = 0;
        streak = 0; last_load = '0; mreq_len = 0;
      end else begin
        done_now = bus.if_done || bus.d_done;
        done_due = p_mreq && p_ack;
        if (done_now || done_due) begin
          chk("done_timing", 32'(done_now), 32'(done_due));
          chk("single_done", 32'(bus.if_done && bus.d_done), 32'd0);
          if (done_now) begin
            done_count++;
            if (exp_q.size() == 0) begin
              chk("sb_depth", 32'(exp_q.size()), 32'd1);
            end else begin
              e = exp_q.pop_front();
              chk("done_is_fetch", 32'(bus.if_done), 32'(e.fetch));
              if (e.fetch) chk("if_rdata", bus.if_rdata, e.rdata);
              else         chk("d_rdata", bus.d_rdata, e.rdata);
            end
          end
        end
        if (p_mreq && !p_ack) chk("mreq_until_ack", 32'(bus.mem_req), 32'd1);
        if (bus.mem_req && !p_mreq) begin
          win_f = p_if && (!p_d || (GUARD && streak == LIMIT));
          chk("grant_has_req", 32'(p_if || p_d), 32'd1);
          if (win_f) begin
            streak = 0;
            chk("fetch_addr", bus.mem_addr, p_if_addr);
            chk("fetch_we", 32'(bus.mem_we), 32'd0);
            chk("fetch_be", 32'(bus.mem_be), 32'hF);
            exp_q.push_back('{1'b1, mem_word(p_if_addr)});
          end else begin
            if (p_if) streak++;
            chk("data_addr", bus.mem_addr, p_d_addr);
            chk("data_we", 32'(bus.mem_we), 32'(p_d_we));
            chk("data_be", 32'(bus.mem_be), 32'(p_d_be));
            if (p_d_we) chk("data_wdata", bus.mem_wdata, p_d_wdata);
            else        last_load = mem_word(p_d_addr);
            exp_q.push_back('{1'b0, last_load});
          end
          grant_log.push_back(win_f);
          cap_addr  = bus.mem_addr;
          cap_wdata = bus.mem_wdata;
          cap_ctl   = 32'({bus.mem_we, bus.mem_be});
          mreq_len  = 1;
        end else if (bus.mem_req) begin
          chk("hold_addr", bus.mem_addr, cap_addr);
          chk("hold_wdata", bus.mem_wdata, cap_wdata);
          chk("hold_ctl", 32'({bus.mem_we, bus.mem_be}), cap_ctl);
          mreq_len++;
        end else if (p_mreq) begin
          last_mreq_len = mreq_len;
        end
        p_mreq = bus.mem_req;  p_ack = bus.mem_ack;
        p_if = bus.if_req;     p_if_addr = bus.if_addr;
        p_d = bus.d_req;       p_d_we = bus.d_we;
        p_d_addr = bus.d_addr; p_d_wdata = bus.d_wdata; p_d_be = bus.d_be;
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_mem_req"},   32'(bus.mem_req), 32'd0);
    chk({tag, "_mem_we"},    32'(bus.mem_we), 32'd0);
    chk({tag, "_mem_addr"},  bus.mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    chk({tag, "_mem_be"},    32'(bus.mem_be), 32'd0);
    chk({tag, "_if_done"},   32'(bus.if_done), 32'd0);
    chk({tag, "_d_done"},    32'(bus.d_done), 32'd0);
    chk({tag, "_if_rdata"},  bus.if_rdata, 32'd0);
    chk({tag, "_d_rdata"},   bus.d_rdata, 32'd0);
  endtask

  // Requester tasks start and end just after a rising edge.
  task automatic fetch_txn(input logic [31:0] a);
    int n;
    n = 0;
    bus.if_addr = a;
    bus.if_req  = 1'b1;
    do begin @(posedge clk); #1; n++; end while (!bus.if_done && n < 200);
    if (!bus.if_done) chk("fetch_timeout", 32'(bus.if_done), 32'd1);
    bus.if_req = 1'b0;
  endtask

  task automatic data_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be);
    int n;
    n = 0;
    bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd; bus.d_be = be;
    bus.d_req = 1'b1;
    do begin @(posedge clk); #1; n++; end while (!bus.d_done && n < 200);
    if (!bus.d_done) chk("data_timeout", 32'(bus.d_done), 32'd1);
    bus.d_req = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic fetch_agent(input int n);
    for (int i = 0; i < n; i++) begin
      idle_cycles(int'($urandom_range(0, 3)));
      fetch_txn($urandom() & 32'hFFFF_FFFC);
    end
  endtask

  task automatic data_agent(input int n);
    for (int i = 0; i < n; i++) begin
      idle_cycles(int'($urandom_range(0, 3)));
      data_txn(1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC, $urandom(),
               4'($urandom_range(0, 15)));
    end
  endtask

  initial begin
    int first_req, done_cyc, snap;
    bus.if_req = 0; bus.if_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
    rst = 1'b0;
    #2 rst = 1'b1;
    #1 check_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle_cycles(2);

    // Single fetch, ack one cycle after mem_req.
    ack_wait = 1; first_req = -1; done_cyc = -1;
    fork
      fetch_txn(32'h0000_0010);
      for (int c = 1; c <= 6; c++) begin
        @(posedge clk); #2;
        if (bus.mem_req && first_req < 0) begin
          first_req = c;
          chk("lat_mem_addr", bus.mem_addr, 32'h10);
          chk("lat_mem_we", 32'(bus.mem_we), 32'd0);
        end
        if (bus.if_done && done_cyc < 0) done_cyc = c;
      end
    join
    chk("lat_first_req", 32'(first_req), 32'd1);
    chk("lat_done_cycle", 32'(done_cyc), 32'd3);
    chk("lat_if_rdata", bus.if_rdata, 32'h93);

    // Simultaneous store and fetch: data goes first.
    ack_wait = 0;
    idle_cycles(2);
    grant_log.delete();
    fork
      fetch_txn(32'h0000_0020);
      data_txn(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011);
    join
    chk("order_count", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      chk("order_first_data", 32'(grant_log[0]), 32'd0);
      chk("order_then_fetch", 32'(grant_log[1]), 32'd1);
    end

    // Slow memory with requester address changing mid-transaction.
    ack_wait = 5;
    idle_cycles(2);
    fork
      fetch_txn(32'h0000_0040);
      begin repeat (3) @(posedge clk); #1 bus.if_addr = 32'hFFFF_FFF0; end
    join
    idle_cycles(1);
    chk("stall_len", 32'(last_mreq_len), 32'd6);

    // Reset in the middle of a memory access.
    ack_wait = 20;
    idle_cycles(2);
    bus.if_addr = 32'h0000_0080;
    bus.if_req  = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_zero("mid_rst");
    bus.if_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    snap = done_count;
    idle_cycles(8);
    chk("no_done_after_rst", 32'(done_count - snap), 32'd0);

    // Both requesting continuously: grant pattern depends on the starvation guard.
    ack_wait = 0;
    grant_log.delete();
    bus.if_addr = 32'h0000_0300;
    bus.d_we = 1'b0; bus.d_addr = 32'h0000_0200; bus.d_be = 4'hF;
    bus.if_req = 1'b1; bus.d_req = 1'b1;
    idle_cycles(45);
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    idle_cycles(10);
    chk("starve_grants", 32'(grant_log.size() >= 10), 32'd1);
    for (int i = 0; i < 10 && i < grant_log.size(); i++)
      chk("starve_pattern", 32'(grant_log[i]), 32'(GUARD && (i % 5 == 4)));

    // Randomized concurrent traffic with random memory latency.
    rand_ack = 1'b1;
    fork
      fetch_agent(40);
      data_agent(40);
    join
    rand_ack = 1'b0;
    idle_cycles(10);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
